// File: rtl/hmc_port_responder_pkg.sv
// Shared definitions for the HMC user-port responder: command codes, limits, error codes, FSM states.
package hmc_resp_pkg;

  localparam logic [3:0] HMC_CMD_RD = 4'h6;
  localparam logic [3:0] HMC_CMD_WR = 4'h8;

  localparam int FLIT_BYTES = 16;
  localparam int MAX_FLITS  = 8;

  localparam logic [6:0] ERR_UNSUP_CMD = 7'h01;
  localparam logic [6:0] ERR_BAD_SIZE  = 7'h02;

  typedef enum logic [1:0] {
    TRAIN,
    IDLE,
    RD_BURST,
    WR_DATA
  } state_t;

  // Read-class codes share bits [2:1] = 2'b11; such commands owe the initiator a response beat.
  function automatic logic is_read_class(input logic [3:0] code);
    return (code[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/hmc_port_responder_if.sv
// Command / write-data / read-data bus between an HMC-port initiator and the responder.
interface hmc_port_responder_if #(
  parameter int TAG_WIDTH  = 6,
  parameter int SIZE_WIDTH = 4,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 128
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [SIZE_WIDTH-1:0] size;
  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_data_valid;
  logic                  wr_data_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [TAG_WIDTH-1:0]  rd_data_tag;
  logic                  rd_data_valid;
  logic                  dinv;

  modport master (
    output cmd_valid, cmd, addr, size, tag, wr_data, wr_data_valid,
    input  cmd_ready, wr_data_ready, rd_data, rd_data_tag, rd_data_valid, dinv
  );

  modport slave (
    input  cmd_valid, cmd, addr, size, tag, wr_data, wr_data_valid,
    output cmd_ready, wr_data_ready, rd_data, rd_data_tag, rd_data_valid, dinv
  );
endinterface

// File: rtl/hmc_port_responder_mem.sv
// Single-port synchronous RAM, one-cycle read, write-first on a same-address write.
module hmc_resp_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/hmc_port_responder.sv
// BRAM-backed responder for the HMC controller user port: services RD/WR commands from local
// memory and returns tagged read flits a fixed RD_LATENCY cycles after each read-beat issue.
module hmc_port_responder
  import hmc_resp_pkg::*;
#(
  parameter int TAG_WIDTH    = 6,
  parameter int SIZE_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 34,
  parameter int DATA_WIDTH   = 128,
  parameter int MEM_AW       = 10,
  parameter int RD_LATENCY   = 4,
  parameter int TRAIN_CYCLES = 16
) (
  input  logic                tx_clk,
  input  logic                rst,
  output logic                hmc_trained,
  hmc_port_responder_if.slave bus,
  output logic [6:0]          errstat,
  output logic [31:0]         rd_beat_count,
  output logic [31:0]         wr_beat_count
);
  localparam int TCW = $clog2(TRAIN_CYCLES + 1);

  state_t                state;
  logic [TCW-1:0]        train_cnt;
  logic [MEM_AW-1:0]     idx;
  logic [SIZE_WIDTH-1:0] remaining;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  cmd_ready_q;
  logic                  wr_ready_q;

  logic                  p_valid [RD_LATENCY];
  logic                  p_dinv  [RD_LATENCY];
  logic [TAG_WIDTH-1:0]  p_tag   [RD_LATENCY];

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] data_tail;
  logic                  size_ok;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr[ADDR_WIDTH-1:MEM_AW+4], bus.addr[3:0]};
  assign size_ok = (bus.size != '0) && (bus.size <= SIZE_WIDTH'(MAX_FLITS));
  assign mem_we  = wr_ready_q && bus.wr_data_valid;

  hmc_resp_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk  (tx_clk),
    .we   (mem_we),
    .addr (idx),
    .wdata(bus.wr_data),
    .rdata(ram_q)
  );

  // RAM contributes one cycle of latency; the data delay line supplies the rest.
  if (RD_LATENCY > 1) begin : g_dly
    logic [DATA_WIDTH-1:0] dly [RD_LATENCY-1];
    always_ff @(posedge tx_clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LATENCY - 1; i++) dly[i] <= '0;
      end else begin
        dly[0] <= ram_q;
        for (int unsigned i = 1; i < RD_LATENCY - 1; i++) dly[i] <= dly[i-1];
      end
    end
    assign data_tail = dly[RD_LATENCY-2];
  end else begin : g_nodly
    assign data_tail = ram_q;
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.wr_data_ready = wr_ready_q;
  assign bus.rd_data_valid = p_valid[RD_LATENCY-1];
  assign bus.rd_data_tag   = p_tag[RD_LATENCY-1];
  assign bus.dinv          = p_dinv[RD_LATENCY-1];
  assign bus.rd_data       = (p_valid[RD_LATENCY-1] && !p_dinv[RD_LATENCY-1]) ? data_tail : '0;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state         <= TRAIN;
      train_cnt     <= '0;
      hmc_trained   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      idx           <= '0;
      remaining     <= '0;
      tag_q         <= '0;
      errstat       <= '0;
      rd_beat_count <= '0;
      wr_beat_count <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        p_valid[i] <= 1'b0;
        p_dinv[i]  <= 1'b0;
        p_tag[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_dinv[i]  <= p_dinv[i-1];
        p_tag[i]   <= p_tag[i-1];
      end
      p_valid[0] <= 1'b0;
      p_dinv[0]  <= 1'b0;
      p_tag[0]   <= '0;

      if (p_valid[RD_LATENCY-1]) rd_beat_count <= rd_beat_count + 32'd1;

      case (state)
        TRAIN: begin
          if (train_cnt == TCW'(TRAIN_CYCLES - 1)) begin
            hmc_trained <= 1'b1;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (bus.cmd_valid) begin
            idx       <= bus.addr[MEM_AW+3:4];
            remaining <= bus.size;
            tag_q     <= bus.tag;
            if (bus.cmd == HMC_CMD_RD && size_ok) begin
              cmd_ready_q <= 1'b0;
              state       <= RD_BURST;
            end else if (bus.cmd == HMC_CMD_WR && size_ok) begin
              cmd_ready_q <= 1'b0;
              wr_ready_q  <= 1'b1;
              state       <= WR_DATA;
            end else begin
              // Dropped command: first error is kept; read-class codes still get a dinv beat.
              if (errstat == '0)
                errstat <= (bus.cmd != HMC_CMD_RD && bus.cmd != HMC_CMD_WR) ? ERR_UNSUP_CMD : ERR_BAD_SIZE;
              if (is_read_class(bus.cmd)) begin
                p_valid[0] <= 1'b1;
                p_dinv[0]  <= 1'b1;
                p_tag[0]   <= bus.tag;
              end
            end
          end
        end

        RD_BURST: begin
          p_valid[0] <= 1'b1;
          p_tag[0]   <= tag_q;
          idx        <= idx + 1'b1;
          if (remaining == SIZE_WIDTH'(1)) begin
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end

        WR_DATA: begin
          if (bus.wr_data_valid) begin
            idx           <= idx + 1'b1;
            wr_beat_count <= wr_beat_count + 32'd1;
            if (remaining == SIZE_WIDTH'(1)) begin
              cmd_ready_q <= 1'b1;
              wr_ready_q  <= 1'b0;
              state       <= IDLE;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end

        default: state <= TRAIN;
      endcase
    end
  end
endmodule

// File: tb/tb_hmc_port_responder.sv
// Directed bench for hmc_port_responder: training, write/read, bursts, errors, wrap/alias, reset.
module tb_hmc_port_responder;
  logic        tx_clk = 1'b0;
  logic        rst;
  logic        hmc_trained;
  logic [6:0]  errstat;
  logic [31:0] rd_beat_count;
  logic [31:0] wr_beat_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int           c;
    logic [5:0]   tag;
    logic [127:0] data;
    logic         dinv;
  } resp_t;
  resp_t resp_q[$];

  hmc_port_responder_if #(.TAG_WIDTH(6), .SIZE_WIDTH(4), .ADDR_WIDTH(34), .DATA_WIDTH(128)) bus ();

  hmc_port_responder #(
    .TAG_WIDTH(6), .SIZE_WIDTH(4), .ADDR_WIDTH(34), .DATA_WIDTH(128),
    .MEM_AW(10), .RD_LATENCY(4), .TRAIN_CYCLES(16)
  ) dut (
    .tx_clk       (tx_clk),
    .rst          (rst),
    .hmc_trained  (hmc_trained),
    .bus          (bus),
    .errstat      (errstat),
    .rd_beat_count(rd_beat_count),
    .wr_beat_count(wr_beat_count)
  );

  always #5 tx_clk = ~tx_clk;
  always @(posedge tx_clk) cyc <= cyc + 1;

  always @(negedge tx_clk)
    if (bus.rd_data_valid === 1'b1)
      resp_q.push_back('{c: cyc, tag: bus.rd_data_tag, data: bus.rd_data, dinv: bus.dinv});

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [33:0] a, input logic [3:0] s,
                          input logic [5:0] t, output int acc);
    bus.cmd_valid = 1'b1;
    bus.cmd = c; bus.addr = a; bus.size = s; bus.tag = t;
    for (int i = 0; i < 100 && bus.cmd_ready !== 1'b1; i++) tick();
    check("cmd_ready_seen", bus.cmd_ready, 1'b1);
    acc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_flit(input logic [127:0] d);
    bus.wr_data_valid = 1'b1;
    bus.wr_data = d;
    for (int i = 0; i < 100 && bus.wr_data_ready !== 1'b1; i++) tick();
    check("wr_ready_seen", bus.wr_data_ready, 1'b1);
    tick();
    bus.wr_data_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 200 && resp_q.size() < n; i++) tick();
    tick();
    check("resp_count", 128'(resp_q.size()), 128'(n));
  endtask

  int acc;
  int accs [32];
  logic bad;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd = 4'h6; bus.addr = '0; bus.size = 4'd1; bus.tag = 6'd0;
    bus.wr_data = '0; bus.wr_data_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_trained", hmc_trained, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_wr_ready", bus.wr_data_ready, 1'b0);
    check("rst_rd_valid", bus.rd_data_valid, 1'b0);
    check("rst_errstat", errstat, 7'h00);
    check("rst_counts", {rd_beat_count, wr_beat_count}, 64'h0);

    // Training with cmd_valid held: 16 cycles of not-ready, then both rise
    rst = 1'b0;
    bad = (hmc_trained !== 1'b0) || (bus.cmd_ready !== 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      if (hmc_trained !== 1'b0 || bus.cmd_ready !== 1'b0) bad = 1'b1;
    end
    check("train_low_16", bad, 1'b0);
    tick();
    check("train_trained", hmc_trained, 1'b1);
    check("train_cmd_ready", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b0;
    repeat (8) tick();
    check("train_no_accept", 128'(resp_q.size()), 128'd0);

    // Single write then read of flit 4
    send_cmd(4'h8, 34'h40, 4'd1, 6'd5, acc);
    write_flit({16{8'hA5}});
    resp_q.delete();
    send_cmd(4'h6, 34'h40, 4'd1, 6'd9, acc);
    wait_resp(1);
    check("single_data", resp_q[0].data, {16{8'hA5}});
    check("single_tag", resp_q[0].tag, 6'd9);
    check("single_dinv", resp_q[0].dinv, 1'b0);
    check("single_latency", 128'(resp_q[0].c), 128'(acc + 5));
    check("single_wr_cnt", wr_beat_count, 32'd1);
    check("single_rd_cnt", rd_beat_count, 32'd1);

    // Burst read of flits 0..3
    send_cmd(4'h8, 34'h0, 4'd4, 6'd1, acc);
    for (int i = 0; i < 4; i++) write_flit(128'(i));
    resp_q.delete();
    send_cmd(4'h6, 34'h0, 4'd4, 6'd3, acc);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cmd_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    check("burst_ready_low4", bad, 1'b0);
    check("burst_ready_back", bus.cmd_ready, 1'b1);
    wait_resp(4);
    for (int i = 0; i < 4; i++) begin
      check("burst_data", resp_q[i].data, 128'(i));
      check("burst_tag", resp_q[i].tag, 6'd3);
      check("burst_cycle", 128'(resp_q[i].c), 128'(acc + 5 + i));
    end

    // Back-to-back size-1 reads, tags 0..31
    resp_q.delete();
    for (int i = 0; i < 32; i++) begin
      send_cmd(4'h6, 34'((i % 4) * 16), 4'd1, 6'(i), accs[i]);
      if (i > 0) check("b2b_spacing", 128'(accs[i] - accs[i-1]), 128'd2);
    end
    wait_resp(32);
    for (int i = 0; i < 32; i++) begin
      check("b2b_tag", resp_q[i].tag, 6'(i));
      check("b2b_data", resp_q[i].data, 128'(i % 4));
      check("b2b_cycle", 128'(resp_q[i].c), 128'(accs[i] + 5));
    end

    // Undefined read-class command: error + dinv beat with original tag
    resp_q.delete();
    send_cmd(4'hF, 34'h0, 4'd1, 6'h2A, acc);
    check("err_unsup", errstat, 7'h01);
    check("err_stay_idle", bus.cmd_ready, 1'b1);
    wait_resp(1);
    check("dinv_flag", resp_q[0].dinv, 1'b1);
    check("dinv_data", resp_q[0].data, 128'h0);
    check("dinv_tag", resp_q[0].tag, 6'h2A);
    check("dinv_cycle", 128'(resp_q[0].c), 128'(acc + 4));
    resp_q.delete();
    send_cmd(4'h6, 34'h0, 4'd1, 6'd2, acc);
    wait_resp(1);
    check("err_mem_unchanged", resp_q[0].data, 128'h0);

    // Size 0 write: dropped silently, error stays sticky
    resp_q.delete();
    send_cmd(4'h8, 34'h0, 4'd0, 6'd1, acc);
    repeat (8) tick();
    check("size0_sticky", errstat, 7'h01);
    check("size0_no_resp", 128'(resp_q.size()), 128'd0);
    check("size0_no_write", wr_beat_count, 32'd5);

    // Size 9 read: dropped with a dinv beat
    send_cmd(4'h6, 34'h0, 4'd9, 6'd7, acc);
    wait_resp(1);
    check("size9_dinv", resp_q[0].dinv, 1'b1);
    check("size9_tag", resp_q[0].tag, 6'd7);
    check("size9_sticky", errstat, 7'h01);
    check("err_rd_cnt", rd_beat_count, 32'd40);

    // Index wrap at the top of memory
    send_cmd(4'h8, 34'h3FF0, 4'd2, 6'd1, acc);
    write_flit(128'h11);
    write_flit(128'h22);
    resp_q.delete();
    send_cmd(4'h6, 34'h3FF0, 4'd2, 6'd4, acc);
    wait_resp(2);
    check("wrap_top", resp_q[0].data, 128'h11);
    check("wrap_zero", resp_q[1].data, 128'h22);

    // Upper address bits alias onto flit 0
    send_cmd(4'h8, 34'h4000, 4'd1, 6'd1, acc);
    write_flit(128'hDEAD_BEEF);
    resp_q.delete();
    send_cmd(4'h6, 34'h0, 4'd1, 6'd6, acc);
    wait_resp(1);
    check("alias_data", resp_q[0].data, 128'hDEAD_BEEF);
    check("pre_rst_rd_cnt", rd_beat_count, 32'd43);
    check("pre_rst_wr_cnt", wr_beat_count, 32'd8);

    // Reset during a size-8 burst after two beats have emerged
    resp_q.delete();
    send_cmd(4'h6, 34'h0, 4'd8, 6'd4, acc);
    while (cyc < acc + 6) tick();
    rst = 1'b1;
    tick();
    check("midrst_valid", bus.rd_data_valid, 1'b0);
    check("midrst_counts", {rd_beat_count, wr_beat_count}, 64'h0);
    check("midrst_errstat", errstat, 7'h00);
    check("midrst_trained", hmc_trained, 1'b0);
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rd_data_valid !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet", bad, 1'b0);
    check("midrst_beats", 128'(resp_q.size()), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hmc_port_responder.md
Name: hmc_port_responder

Overview:
- BRAM-backed stand-in for the HMC controller user port. It is the responder end of the cmd/wr_data/rd_data interface that our GUPS-style initiators drive.
- Accepts RD/WR commands, services them from local memory, and returns tagged read flits with fixed latency.
- Used for on-board bring-up and bench regression of initiator blocks without a trained HMC link.

Parameters:
- TAG_WIDTH, 6, request/response tag width
- SIZE_WIDTH, 4, request size field width (units of 16-byte flits)
- ADDR_WIDTH, 34, byte address width
- DATA_WIDTH, 128, flit width
- MEM_AW, 10, log2 of memory depth in flits
- RD_LATENCY, 4, cycles from read-beat issue to rd_data_valid; minimum 1
- TRAIN_CYCLES, 16, cycles after reset release before hmc_trained rises

Ports:
- tx_clk  in  1  sole clock
- rst  in  1  reset; synchronous, active-high
- hmc_trained  out  1  link-ready indication to the initiator
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on cmd_valid&&cmd_ready
- cmd  in  4  HMC command code
- addr  in  ADDR_WIDTH  byte address
- size  in  SIZE_WIDTH  flits; legal range 1..8
- tag  in  TAG_WIDTH  request tag
- wr_data  in  DATA_WIDTH  write flit
- wr_data_valid  in  1  write flit present
- wr_data_ready  out  1  write flit accepted on valid&&ready
- rd_data  out  DATA_WIDTH  read flit
- rd_data_tag  out  TAG_WIDTH  tag of the read flit
- rd_data_valid  out  1  read flit strobe; no backpressure exists
- errstat  out  7  sticky error code
- dinv  out  1  data-invalid marker on rd_data
- rd_beat_count  out  32  read flits returned
- wr_beat_count  out  32  write flits committed

Behaviour:
- Reset: all outputs are 0, the FSM is in TRAIN, the latency pipe is flushed and the train counter is cleared. Memory contents are not cleared.
- Reset mid-operation: the burst is abandoned and rd_data_valid is 0 from the next cycle.
- FSM states: TRAIN, IDLE, RD_BURST, WR_DATA.
- TRAIN: counts TRAIN_CYCLES, then hmc_trained is set to 1 (held until reset) and the FSM goes to IDLE. cmd_ready and wr_data_ready are 0 while in TRAIN.
- cmd_ready=1 only in IDLE. cmd_ready never depends on cmd_valid.
- Accept in IDLE: latch cmd/addr/size/tag. Flit index = addr[MEM_AW+3:4]. addr[3:0] is ignored. Upper address bits alias (wrap modulo depth).
  - cmd==HMC_CMD_RD, legal size: go to RD_BURST.
  - cmd==HMC_CMD_WR, legal size: go to WR_DATA.
  - Any other cmd, or size 0 or >8: command is dropped and the FSM stays in IDLE.
- Error flagging for dropped commands: errstat is set to 7'h01 (unsupported cmd) or 7'h02 (illegal size), first error wins, sticky until reset. If the dropped command was a read-class code, one rd_data_valid beat is issued with dinv=1, rd_data=0 and the original tag, RD_LATENCY cycles later.
- RD_BURST:
  - Issues one memory read per cycle for `size` consecutive flit indices; the index wraps at the depth.
  - Each beat emerges with rd_data_valid=1, the latched tag and dinv=0, exactly RD_LATENCY cycles after its issue cycle.
  - Beats of one burst are contiguous and in address order.
  - Returns to IDLE in the cycle the last beat issues. The next command can be accepted the following cycle.
- WR_DATA:
  - wr_data_ready=1. Each accepted flit is written to memory at the current index, and the index is incremented.
  - Returns to IDLE after `size` flits. Cycles without wr_data_valid simply stall.
  - wr_data_ready=0 in every other state; early write data waits upstream.
- Ordering: a write completes in memory before the next command is accepted, so a read accepted after a write to the same address returns the new data.
- rd_beat_count increments once per rd_data_valid cycle, including dinv beats. wr_beat_count increments once per committed flit. Both counters wrap at 2^32.
- The pipeline is a RD_LATENCY-deep shift register of {valid, tag, dinv}, aligned with RAM output. The RAM has 1-cycle read latency; the remaining RD_LATENCY-1 stages are register delay.

Decomposition:
- Package hmc_resp_pkg holds:
  - HMC_CMD_RD and HMC_CMD_WR codes, matching hmc_def values
  - FLIT_BYTES=16 and MAX_FLITS=8
  - ERR_UNSUP_CMD=7'h01 and ERR_BAD_SIZE=7'h02
  - state enum {TRAIN, IDLE, RD_BURST, WR_DATA}
- Sub-module hmc_resp_mem: single-port synchronous RAM, DATA_WIDTH x 2^MEM_AW, 1-cycle read, write-first. The top-level arbitrates port use through the FSM states.

Test Plan:
- Training: release rst, hold cmd_valid=1 -> cmd_ready=0 and hmc_trained=0 for 16 cycles, then both rise. No accept occurs before that.
- Single write/read:
  - Stimulus: WR addr 0x40 size 1 tag 5 with data 0xA5..A5, then RD addr 0x40 tag 9 issued in cycle T.
  - Response: rd_data=0xA5..A5, tag 9, valid in cycle T+4, wr_beat_count=1, rd_beat_count=1.
- Burst read:
  - Stimulus: preload flits 0..3 with values 0..3, then RD addr 0x0 size 4 tag 3.
  - Response: 4 consecutive valid beats with data 0,1,2,3, all tag 3, and cmd_ready low for 4 cycles.
- Initiator pattern: 32 back-to-back size-1 reads with tags 0..31 -> 32 responses in tag order, one per IDLE/RD_BURST pair, each exactly 4 cycles after issue.
- Errors:
  - cmd=4'hF (read-class undefined): errstat=7'h01, one dinv=1 beat with the original tag, memory unchanged.
  - Size 0: errstat stays 7'h01 (sticky, first error wins).
- Reset mid-burst and aliasing:
  - rst asserted during a RD size-8 burst -> rd_data_valid=0 from the next cycle onward, and counters read 0.
  - Write to addr 0x4000 (MEM_AW=10) reads back at addr 0x0.
